// File: rtl/alu_pkg.sv
// Shared ALU operation codes, RV32I opcodes, operand-select codes and the
// decode bundle carried from the decoder to execute.
package alu_pkg;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_SLT  = 5'b00010;
    localparam logic [4:0] ALU_SLTU = 5'b00011;
    localparam logic [4:0] ALU_AND  = 5'b00100;
    localparam logic [4:0] ALU_OR   = 5'b00101;
    localparam logic [4:0] ALU_XOR  = 5'b00110;
    localparam logic [4:0] ALU_SLL  = 5'b00111;
    localparam logic [4:0] ALU_SRL  = 5'b01000;
    localparam logic [4:0] ALU_SRA  = 5'b01001;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] SRC_A_RS1  = 2'b00;
    localparam logic [1:0] SRC_A_PC   = 2'b01;
    localparam logic [1:0] SRC_A_ZERO = 2'b10;
    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    typedef struct packed {
        logic [4:0]  aluop;
        logic [1:0]  src_a;
        logic [1:0]  src_b;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] pc;
        logic        illegal;
    } decode_t;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic logic [4:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
        logic [4:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_op_decode_comb.sv
// Purely combinational RV32I instruction word + PC to ALU decode bundle.
module alu_op_decode_comb
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output decode_t     bundle
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] imm_sh;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign rd     = instr[11:7];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_sh = {27'b0, instr[24:20]};

    logic       legal;
    logic       writes;
    logic [4:0] aluop;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [31:0] imm;

    always_comb begin
        legal  = 1'b1;
        writes = 1'b0;
        aluop  = ALU_ADD;
        src_a  = SRC_A_RS1;
        src_b  = SRC_B_RS2;
        imm    = 32'b0;
        case (opcode)
            OPC_OP: begin
                writes = 1'b1;
                aluop  = alu_from_funct3(f3, f7[5]);
                legal  = (f7 == F7_ZERO) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                writes = 1'b1;
                src_b  = SRC_B_IMM;
                // funct7 only distinguishes SRLI/SRAI; ADDI has no SUB form
                aluop  = alu_from_funct3(f3, (f3 == 3'b101) && f7[5]);
                case (f3)
                    3'b001: begin
                        legal = (f7 == F7_ZERO);
                        imm   = imm_sh;
                    end
                    3'b101: begin
                        legal = (f7 == F7_ZERO) || (f7 == F7_ALT);
                        imm   = imm_sh;
                    end
                    default: imm = imm_i;
                endcase
            end
            OPC_LUI: begin
                writes = 1'b1;
                src_a  = SRC_A_ZERO;
                src_b  = SRC_B_IMM;
                imm    = imm_u;
            end
            OPC_AUIPC: begin
                writes = 1'b1;
                src_a  = SRC_A_PC;
                src_b  = SRC_B_IMM;
                imm    = imm_u;
            end
            OPC_LOAD: begin
                writes = 1'b1;
                src_b  = SRC_B_IMM;
                imm    = imm_i;
            end
            OPC_STORE: begin
                src_b = SRC_B_IMM;
                imm   = imm_s;
            end
            OPC_BRANCH: begin
                imm = imm_b;
                case (f3)
                    3'b000, 3'b001: aluop = ALU_SUB;
                    3'b100, 3'b101: aluop = ALU_SLT;
                    3'b110, 3'b111: aluop = ALU_SLTU;
                    default:        legal = 1'b0;
                endcase
            end
            OPC_JAL: begin
                writes = 1'b1;
                src_a  = SRC_A_PC;
                src_b  = SRC_B_FOUR;
                imm    = imm_j;
            end
            OPC_JALR: begin
                writes = 1'b1;
                legal  = (f3 == 3'b000);
                src_a  = SRC_A_PC;
                src_b  = SRC_B_FOUR;
                imm    = imm_i;
            end
            default: legal = 1'b0;
        endcase

        bundle.rs1     = instr[19:15];
        bundle.rs2     = instr[24:20];
        bundle.rd      = rd;
        bundle.pc      = pc;
        bundle.illegal = !legal;
        bundle.aluop   = legal ? aluop : ALU_ADD;
        bundle.src_a   = legal ? src_a : SRC_A_RS1;
        bundle.src_b   = legal ? src_b : SRC_B_RS2;
        bundle.imm     = legal ? imm : 32'b0;
        bundle.rd_we   = legal && writes && (rd != 5'd0);
    end

endmodule

// File: rtl/alu_op_decoder.sv
// Decode stage: registered decode bundle with a one-entry skid behind the
// output register, plus a saturating count of accepted illegal encodings.
module alu_op_decoder
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_aluop,
    output logic [1:0]       out_src_a,
    output logic [1:0]       out_src_b,
    output logic [31:0]      out_imm,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic             out_rd_we,
    output logic [31:0]      out_pc,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    decode_t          dec;
    decode_t          out_reg;
    decode_t          skid_reg;
    logic             out_valid_reg;
    logic             skid_valid_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             accept;
    logic             fire;

    alu_op_decode_comb u_decode (
        .instr  (in_instr),
        .pc     (in_pc),
        .bundle (dec)
    );

    assign in_ready = !skid_valid_reg && !rst;
    assign accept   = in_valid && in_ready;
    assign fire     = out_valid_reg && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg        <= '0;
            skid_reg       <= '0;
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            // A full skid forces in_ready low, so accept never coincides with skid drain
            if (fire) begin
                if (skid_valid_reg) begin
                    out_reg        <= skid_reg;
                    skid_valid_reg <= 1'b0;
                end else if (accept) begin
                    out_reg <= dec;
                end else begin
                    out_valid_reg <= 1'b0;
                end
            end else if (accept) begin
                if (out_valid_reg) begin
                    skid_reg       <= dec;
                    skid_valid_reg <= 1'b1;
                end else begin
                    out_reg       <= dec;
                    out_valid_reg <= 1'b1;
                end
            end
            if (accept && dec.illegal && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_aluop   = out_reg.aluop;
    assign out_src_a   = out_reg.src_a;
    assign out_src_b   = out_reg.src_b;
    assign out_imm     = out_reg.imm;
    assign out_rs1     = out_reg.rs1;
    assign out_rs2     = out_reg.rs2;
    assign out_rd      = out_reg.rd;
    assign out_rd_we   = out_reg.rd_we;
    assign out_pc      = out_reg.pc;
    assign out_illegal = out_reg.illegal;
    assign illegal_cnt = cnt_reg;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed bench for alu_op_decoder: single-instruction decodes, back-pressure
// ordering through the skid, illegal counting and reset during a stall.
module tb_alu_op_decoder;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [31:0]      in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_aluop;
    logic [1:0]       out_src_a;
    logic [1:0]       out_src_b;
    logic [31:0]      out_imm;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [4:0]       out_rd;
    logic             out_rd_we;
    logic [31:0]      out_pc;
    logic             out_illegal;
    logic [CNT_W-1:0] illegal_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_op_decoder #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_aluop   (out_aluop),
        .out_src_a   (out_src_a),
        .out_src_b   (out_src_b),
        .out_imm     (out_imm),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd      (out_rd),
        .out_rd_we   (out_rd_we),
        .out_pc      (out_pc),
        .out_illegal (out_illegal),
        .illegal_cnt (illegal_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Issue one instruction with out_ready=1, then check the bundle one cycle later
    task automatic run_one(input string name, input logic [31:0] instr, input logic [31:0] pc,
                           input logic [4:0] e_aluop, input logic [1:0] e_src_a,
                           input logic [1:0] e_src_b, input logic [31:0] e_imm,
                           input logic [4:0] e_rd, input logic e_rd_we,
                           input logic e_illegal, input logic [31:0] e_cnt);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_val({name, "_valid"},   out_valid,   1);
        check_val({name, "_aluop"},   out_aluop,   e_aluop);
        check_val({name, "_src_a"},   out_src_a,   e_src_a);
        check_val({name, "_src_b"},   out_src_b,   e_src_b);
        check_val({name, "_imm"},     out_imm,     e_imm);
        check_val({name, "_rd"},      out_rd,      e_rd);
        check_val({name, "_rd_we"},   out_rd_we,   e_rd_we);
        check_val({name, "_illegal"}, out_illegal, e_illegal);
        check_val({name, "_pc"},      out_pc,      pc);
        check_val({name, "_cnt"},     illegal_cnt, e_cnt);
        $display("txn %s instr=%h aluop=%0d src_a=%0d src_b=%0d imm=%h rd=%0d we=%0d ill=%0d cnt=%0d",
                 name, instr, out_aluop, out_src_a, out_src_b, out_imm, out_rd, out_rd_we,
                 out_illegal, illegal_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 32'b0;
        in_pc     = 32'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out_valid", out_valid,   0);
        check_val("rst_in_ready",  in_ready,    0);
        check_val("rst_cnt",       illegal_cnt, 0);
        check_val("rst_aluop",     out_aluop,   0);
        check_val("rst_imm",       out_imm,     0);
        check_val("rst_pc",        out_pc,      0);
        rst = 1'b0;
        #1;
        check_val("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        //      name      instr         pc            aluop   a  b  imm           rd we il cnt
        run_one("add",    32'h002081B3, 32'h00000100, 5'd0,   0, 0, 32'h00000000, 3, 1, 0, 0);
        run_one("srai",   32'h40335293, 32'h00000104, 5'd9,   0, 1, 32'h00000003, 5, 1, 0, 0);
        run_one("lui",    32'h123450B7, 32'h00000108, 5'd0,   2, 1, 32'h12345000, 1, 1, 0, 0);
        run_one("bltu",   32'h0020E463, 32'h0000010C, 5'd3,   0, 0, 32'h00000008, 8, 0, 0, 0);
        run_one("jal",    32'h010000EF, 32'h00000110, 5'd0,   1, 2, 32'h00000010, 1, 1, 0, 0);
        run_one("addi_m1",32'hFFF00093, 32'h00000114, 5'd0,   0, 1, 32'hFFFFFFFF, 1, 1, 0, 0);
        run_one("sw",     32'h0020A223, 32'h00000118, 5'd0,   0, 1, 32'h00000004, 4, 0, 0, 0);
        run_one("add_x0", 32'h00208033, 32'h0000011C, 5'd0,   0, 0, 32'h00000000, 0, 0, 0, 0);
        run_one("ill1",   32'hFFFFFFFF, 32'h00000120, 5'd0,   0, 0, 32'h00000000, 31, 0, 1, 1);
        run_one("ill2",   32'hFFFFFFFF, 32'h00000124, 5'd0,   0, 0, 32'h00000000, 31, 0, 1, 2);
        @(posedge clk);
        #1;
        check_val("drain_valid", out_valid, 0);

        // Back-pressure: I1 held, I2 in skid, I3 stalled, then drain in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h002081B3;
        in_pc     = 32'h00000200;
        @(posedge clk);
        #1;
        check_val("bp_i1_valid",    out_valid, 1);
        check_val("bp_i1_in_ready", in_ready,  1);
        in_instr = 32'h40335293;
        in_pc    = 32'h00000204;
        @(posedge clk);
        #1;
        in_instr = 32'h123450B7;
        in_pc    = 32'h00000208;
        check_val("bp_skid_in_ready", in_ready, 0);
        check_val("bp_hold_rd",       out_rd,   3);
        check_val("bp_hold_pc",       out_pc,   32'h200);
        @(posedge clk);
        #1;
        check_val("bp_stable_rd",    out_rd,    3);
        check_val("bp_stable_aluop", out_aluop, 0);
        check_val("bp_stall_ready",  in_ready,  0);
        $display("txn bp_i1 pc=%h rd=%0d", out_pc, out_rd);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("bp_i2_valid", out_valid, 1);
        check_val("bp_i2_rd",    out_rd,    5);
        check_val("bp_i2_pc",    out_pc,    32'h204);
        check_val("bp_i2_aluop", out_aluop, 9);
        check_val("bp_i2_ready", in_ready,  1);
        $display("txn bp_i2 pc=%h rd=%0d", out_pc, out_rd);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_val("bp_i3_valid", out_valid, 1);
        check_val("bp_i3_rd",    out_rd,    1);
        check_val("bp_i3_pc",    out_pc,    32'h208);
        check_val("bp_i3_src_a", out_src_a, 2);
        $display("txn bp_i3 pc=%h rd=%0d", out_pc, out_rd);
        @(posedge clk);
        #1;
        check_val("bp_empty", out_valid, 0);

        // Reset while both output and skid are occupied
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFFFFFFF;
        in_pc     = 32'h00000300;
        @(posedge clk);
        #1;
        in_instr = 32'h002081B3;
        in_pc    = 32'h00000304;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_val("stall_cnt",     illegal_cnt, 3);
        check_val("stall_ready",   in_ready,    0);
        check_val("stall_illegal", out_illegal, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("mid_rst_valid", out_valid,   0);
        check_val("mid_rst_cnt",   illegal_cnt, 0);
        check_val("mid_rst_ready", in_ready,    0);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("post_rst_skid_gone", out_valid, 0);
        check_val("post_rst_ready",     in_ready,  1);
        $display("txn reset_during_stall valid=%0d cnt=%0d", out_valid, illegal_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
